al_clk_ctrl: RTL

Keypad and mode controller for the alarm clock. It collects BCD digits from the keypad into a 4-digit entry buffer and drives the clock counter's load strobe to set the time. It also holds the alarm-time register, selects what the display shows, and raises the alarm when the running time matches the alarm time. It sits between the keypad decoder and the BCD clock counter and display mux.

---
 rtl/al_clk_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/al_clk_ctrl.sv
// ============================================================================
// al_clk_ctrl : alarm clock keypad entry, time/alarm commit and alarm sounder.
// Optional commit validation: define AL_CLK_CTRL_VALIDATE_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module al_clk_ctrl #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        time_button,
  input  logic        alarm_button,
  input  logic        alarm_on,
  input  logic [15:0] current_time,
  output logic [15:0] key_buffer,
  output logic        load_new_time,
  output logic [15:0] alarm_time,
  output logic        show_keys,
  output logic        show_alarm,
  output logic        sound_alarm,
  output logic        entry_error
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ENTRY      = 3'd1;
  localparam logic [2:0] LOAD_TIME  = 3'd2;
  localparam logic [2:0] LOAD_ALARM = 3'd3;
  localparam logic [2:0] SHOW_ALARM = 3'd4;

  localparam int             CNT_W         = $clog2(TIMEOUT_SECS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_SECS);

  logic [2:0]       state;
  logic [CNT_W-1:0] timeout_cnt;
  logic             is_digit;
  logic             commit_ok;

  assign is_digit = key_valid && (key <= 4'd9);

`ifdef AL_CLK_CTRL_VALIDATE_EN
  // Buffer layout is {ms_hour, ls_hour, ms_min, ls_min}.
  always_comb begin
    commit_ok = (key_buffer[15:12] <= 4'd2) &&
                (key_buffer[11:8]  <= 4'd9) &&
                !((key_buffer[15:12] == 4'd2) && (key_buffer[11:8] > 4'd3)) &&
                (key_buffer[7:4]   <= 4'd5) &&
                (key_buffer[3:0]   <= 4'd9);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_error <= 1'b0;
    end else begin
      entry_error <= (state == ENTRY) && (time_button || alarm_button) && !commit_ok;
    end
  end
`else
  assign commit_ok   = 1'b1;
  assign entry_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_buffer  <= 16'h0000;
      alarm_time  <= 16'h0000;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout_cnt <= '0;
          if (is_digit) begin
            key_buffer <= {key_buffer[11:0], key};
            state      <= ENTRY;
          end else if (alarm_button) begin
            state <= SHOW_ALARM;
          end
        end
        ENTRY: begin
          // Buttons outrank digits, which outrank the timeout.
          if (time_button || alarm_button) begin
            timeout_cnt <= '0;
            if (!commit_ok) begin
              key_buffer <= 16'h0000;
              state      <= IDLE;
            end else if (time_button) begin
              state <= LOAD_TIME;
            end else begin
              alarm_time <= key_buffer;
              state      <= LOAD_ALARM;
            end
          end else if (is_digit) begin
            key_buffer  <= {key_buffer[11:0], key};
            timeout_cnt <= '0;
          end else if (timeout_cnt == TIMEOUT_LIMIT) begin
            key_buffer  <= 16'h0000;
            timeout_cnt <= '0;
            state       <= IDLE;
          end else if (one_second) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        LOAD_TIME, LOAD_ALARM: begin
          key_buffer  <= 16'h0000;
          timeout_cnt <= '0;
          state       <= IDLE;
        end
        SHOW_ALARM: begin
          timeout_cnt <= '0;
          if (!alarm_button) begin
            state <= IDLE;
          end
        end
        default: begin
          key_buffer  <= 16'h0000;
          timeout_cnt <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Sounder latches on a match and only alarm_on releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sound_alarm <= 1'b0;
    end else begin
      sound_alarm <= alarm_on & (sound_alarm | (current_time == alarm_time));
    end
  end

  assign load_new_time = (state == LOAD_TIME);
  assign show_keys     = (state == ENTRY) || (state == LOAD_TIME) || (state == LOAD_ALARM);
  assign show_alarm    = (state == SHOW_ALARM);

endmodule

`default_nettype wire
